// File: rtl/sd_dat_tx_fifo.sv
// sd_dat_tx_fifo: first-word-fall-through word FIFO feeding the SD DAT parallel-to-serial stage
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   flush        synchronous clear of pointers, count and error flags; discards push/pop
//   push/data_in enqueue a word; accepted when not full, or when full with a pop
//   pop          consume the head word; refused when empty
//   data_out     head word, zero while empty
//   fifo_full, fifo_empty, almost_full, almost_empty, count: occupancy status
//   overflow/underflow: sticky refused-push/refused-pop flags, present only when
//   SD_FIFO_ERR_FLAGS_EN is defined
module sd_dat_tx_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [AW:0]           count
`ifdef SD_FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  wr_en, rd_en;
   assign fifo_full    = count == FULL_CNT;
   assign fifo_empty   = count == '0;
   assign almost_full  = count >= AF_CNT;
   assign almost_empty = count <= AE_CNT;
   // a pop frees the slot being written, so a full FIFO still takes a push alongside a pop
   assign wr_en    = push && (!fifo_full || pop) && !flush;
   assign rd_en    = pop && !fifo_empty && !flush;
   assign data_out = fifo_empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clock)
      if (wr_en) mem[wr_ptr] <= data_in;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en) count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
      end
`ifdef SD_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= !flush && (overflow || (push && fifo_full && !pop));
         underflow <= !flush && (underflow || (pop && fifo_empty));
      end
`endif
endmodule

// File: tb/tb_sd_dat_tx_fifo.sv
// tb_sd_dat_tx_fifo: directed self-checking bench for sd_dat_tx_fifo
module tb_sd_dat_tx_fifo;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        push = 1'b0;
   logic [31:0] data_in = '0;
   logic        pop = 1'b0;
   logic [31:0] data_out;
   logic        fifo_full, fifo_empty, almost_full, almost_empty;
   logic [3:0]  count;
`ifdef SD_FIFO_ERR_FLAGS_EN
   logic        overflow, underflow;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   sd_dat_tx_fifo dut (
      .clock(clock), .reset(reset), .flush(flush), .push(push), .data_in(data_in),
      .pop(pop), .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SD_FIFO_ERR_FLAGS_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic p, input logic [31:0] d, input logic q, input logic f);
      push = p;
      data_in = d;
      pop = q;
      flush = f;
      @(posedge clock);
      #1;
      push = 1'b0;
      pop = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #3;
      check("rst_count", count, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_ae", almost_empty, 1);
      check("rst_af", almost_full, 0);
      check("rst_dout", data_out, 0);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);
`endif
      #4 reset = 1'b1;
      @(posedge clock);
      #1;
      // mid-run asynchronous reset with five words stored
      for (int i = 0; i < 5; i++) step(1, 32'hA000_0000 + i, 0, 0);
      check("t1_count5", count, 5);
      check("t1_head", data_out, 32'hA000_0000);
      #2 reset = 1'b0;
      #1;
      check("t1_count0", count, 0);
      check("t1_empty", fifo_empty, 1);
      check("t1_dout", data_out, 0);
      #2 reset = 1'b1;
      // fill to full, then check ordering on drain
      for (int i = 0; i < 8; i++) begin
         step(1, 32'hC000_0003 + i, 0, 0);
         check("t2_count", count, i + 1);
         check("t2_af", almost_full, (i + 1) >= 6);
         check("t2_ae", almost_empty, (i + 1) <= 1);
         check("t2_full", fifo_full, i == 7);
         check("t2_head", data_out, 32'hC000_0003);
      end
      step(1, 32'h1111_1111, 0, 0);
      check("t2_refused_count", count, 8);
      check("t2_refused_head", data_out, 32'hC000_0003);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("t2_ovf", overflow, 1);
`endif
      for (int i = 0; i < 8; i++) begin
         check("t2_pop_data", data_out, 32'hC000_0003 + i);
         step(0, 0, 1, 0);
         check("t2_pop_count", count, 7 - i);
      end
      check("t2_empty", fifo_empty, 1);
      check("t2_dout0", data_out, 0);
      step(0, 0, 0, 1);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("t2_ovf_clr", overflow, 0);
`endif
      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) step(1, 32'hC000_0003 + i, 0, 0);
      step(1, 32'hDEAD_0001, 1, 0);
      check("t3_count", count, 8);
      check("t3_full", fifo_full, 1);
      check("t3_head", data_out, 32'hC000_0004);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("t3_ovf", overflow, 0);
`endif
      for (int i = 0; i < 8; i++) begin
         check("t3_pop_data", data_out, (i == 7) ? 32'hDEAD_0001 : 32'hC000_0004 + i);
         step(0, 0, 1, 0);
      end
      check("t3_empty", fifo_empty, 1);
      // empty FIFO with simultaneous push and pop
      step(1, 32'hC000_E000, 1, 0);
      check("t4_count", count, 1);
      check("t4_dout", data_out, 32'hC000_E000);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("t4_unf", underflow, 1);
      step(0, 0, 0, 0);
      check("t4_unf_sticky", underflow, 1);
`endif
      step(0, 0, 0, 1);
      check("t4_flush_count", count, 0);
`ifdef SD_FIFO_ERR_FLAGS_EN
      check("t4_unf_clr", underflow, 0);
`endif
      // flush wins over a push in the same cycle
      for (int i = 0; i < 4; i++) step(1, 32'hB000_0000 + i, 0, 0);
      check("t5_count4", count, 4);
      step(1, 32'h5555_5555, 0, 1);
      check("t5_count0", count, 0);
      check("t5_empty", fifo_empty, 1);
      check("t5_dout", data_out, 0);
      step(1, 32'h7777_0000, 0, 0);
      check("t5_after", data_out, 32'h7777_0000);
      check("t5_after_count", count, 1);
      step(0, 0, 1, 0);
      // pointer wrap with alternating push/pop
      for (int i = 0; i < 20; i++) begin
         step(1, i, 0, 0);
         check("t6_count1", count, 1);
         check("t6_data", data_out, i);
         step(0, 0, 1, 0);
         check("t6_count0", count, 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
